// File: rtl/io_hd_pkg.sv
// Shared definitions for the half-duplex responder: FSM states, frame geometry
// and the line-level / bit-order constants used by both RX and TX paths.
package io_hd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    TURN,
    TX_START,
    TX_DATA,
    TX_STOP
  } io_state_e;

  localparam int   DEF_DATA_W  = 8;
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = ~IDLE_LEVEL;
  localparam bit   LSB_FIRST   = 1'b1;

  // Start bit + payload + stop bit.
  function automatic int frame_bits(input int data_w);
    return data_w + 2;
  endfunction

  localparam int FRAME_BITS = frame_bits(DEF_DATA_W);

endpackage

// File: rtl/io_bit_timer.sv
// Free-running bit-period down-counter shared by RX and TX. restart realigns
// it so mid_pulse lands BIT_CYCLES/2 cycles and end_pulse BIT_CYCLES cycles later.
module io_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic mid_pulse,
  output logic end_pulse
);

  localparam int CW = $clog2(BIT_CYCLES);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= CW'(BIT_CYCLES - 1);
    end else if (restart || cnt == '0) begin
      cnt <= CW'(BIT_CYCLES - 1);
    end else begin
      cnt <= cnt - CW'(1);
    end
  end

  // The FSM acts on the edge after the pulse is seen, hence BIT_CYCLES/2 not /2-1.
  assign mid_pulse = (cnt == CW'(BIT_CYCLES / 2));
  assign end_pulse = (cnt == '0);

endmodule

// File: rtl/io_half_duplex_responder.sv
// Responder end of a single-wire half-duplex link: receives a command frame,
// releases the line for a turnaround gap, then answers with a buffered byte.
module io_half_duplex_responder
  import io_hd_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BIT_CYCLES  = 4,
  parameter int TURN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  inout  wire               IO,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_err,
  output logic              busy,
  output logic              line_oe,
  output io_state_e         state_dbg
);

  // Core handshake: a byte moves into the response buffer on any cycle where
  // tx_valid && tx_ready; tx_ready is simply "buffer empty" and never depends on tx_valid.

  localparam int FRAME_W = frame_bits(DATA_W);
  localparam int BW      = $clog2(DATA_W);
  localparam int TW      = $clog2(TURN_CYCLES + 1);

  io_state_e         state;
  logic              sync1;
  logic              line_s;
  logic              drv;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] buf_data;
  logic              buf_full;
  logic [BW-1:0]     bit_cnt;
  logic [TW-1:0]     turn_cnt;
  logic              timer_restart;
  logic              mid_pulse;
  logic              end_pulse;
  logic              tx_next_bit;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_shifted;

  assign IO        = line_oe ? drv : 1'bz;
  assign tx_ready  = ~buf_full;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  assign tx_next_bit = LSB_FIRST ? tx_shift[0] : tx_shift[DATA_W-1];
  assign tx_shifted  = LSB_FIRST ? (tx_shift >> 1) : (tx_shift << 1);
  assign rx_shifted  = LSB_FIRST ? {line_s, rx_shift[DATA_W-1:1]}
                                 : {rx_shift[DATA_W-2:0], line_s};

  // Realign the bit timer on every phase change that starts a new bit grid.
  always_comb begin
    timer_restart = 1'b0;
    case (state)
      IDLE:     timer_restart = ~line_oe & ~line_s;
      RX_START: timer_restart = mid_pulse & ~line_s;
      TURN:     timer_restart = (turn_cnt == '0) & buf_full;
      default:  timer_restart = 1'b0;
    endcase
  end

  io_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk       (clk),
    .reset     (reset),
    .restart   (timer_restart),
    .mid_pulse (mid_pulse),
    .end_pulse (end_pulse)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= IDLE_LEVEL;
      line_s <= IDLE_LEVEL;
    end else begin
      sync1  <= IO;
      line_s <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      line_oe   <= 1'b0;
      drv       <= IDLE_LEVEL;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      bit_cnt   <= '0;
      turn_cnt  <= '0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;

      if (tx_valid && !buf_full) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end

      case (state)
        IDLE: begin
          if (!line_oe && !line_s) state <= RX_START;
        end

        RX_START: begin
          if (mid_pulse) begin
            if (line_s) begin
              state <= IDLE;
            end else begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
        end

        RX_DATA: begin
          if (end_pulse) begin
            rx_shift <= rx_shifted;
            bit_cnt  <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(FRAME_W - 3)) state <= RX_STOP;
          end
        end

        RX_STOP: begin
          if (end_pulse) begin
            if (line_s == IDLE_LEVEL) begin
              rx_data  <= rx_shift;
              rx_valid <= 1'b1;
              turn_cnt <= TW'(TURN_CYCLES);
              state    <= TURN;
            end else begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end
          end
        end

        // buf_full here is the registered value, so a same-cycle tx_valid
        // cannot influence whether this turnaround answers.
        TURN: begin
          if (turn_cnt != '0) begin
            turn_cnt <= turn_cnt - TW'(1);
          end else if (buf_full) begin
            state    <= TX_START;
            buf_full <= 1'b0;
            tx_shift <= buf_data;
            line_oe  <= 1'b1;
            drv      <= START_LEVEL;
          end else begin
            state <= IDLE;
          end
        end

        TX_START: begin
          if (end_pulse) begin
            state    <= TX_DATA;
            drv      <= tx_next_bit;
            tx_shift <= tx_shifted;
            bit_cnt  <= '0;
          end
        end

        TX_DATA: begin
          if (end_pulse) begin
            bit_cnt <= bit_cnt + BW'(1);
            if (bit_cnt == BW'(FRAME_W - 3)) begin
              state <= TX_STOP;
              drv   <= IDLE_LEVEL;
            end else begin
              drv      <= tx_next_bit;
              tx_shift <= tx_shifted;
            end
          end
        end

        TX_STOP: begin
          if (end_pulse) begin
            state   <= IDLE;
            line_oe <= 1'b0;
            drv     <= IDLE_LEVEL;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_half_duplex_responder.sv
// Bench for io_half_duplex_responder: initiator model with pull-up, RX
// scoreboard on rx_valid, and per-scenario tasks checking TX waveforms.
module tb_io_half_duplex_responder;
  import io_hd_pkg::*;

  localparam int DW       = 8;
  localparam int BITC     = 4;
  localparam int TURNC    = 2;
  localparam int STOP_OFS = 3 + BITC / 2 + (DW + 1) * BITC;
  localparam int TX_OFS   = STOP_OFS + TURNC + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  wire           io_line;
  logic          init_oe = 1'b0;
  logic          init_drv = 1'b1;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          busy;
  logic          line_oe;
  io_state_e     state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_cnt = 0;
  int err_cnt = 0;
  int rx_cyc = -1;
  int err_cyc = -1;
  bit oe_seen = 1'b0;
  bit model_full = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tx_exp_q[$];
  logic [DW-1:0] exp_b;

  assign io_line = init_oe ? init_drv : 1'bz;
  pullup (io_line);

  io_half_duplex_responder #(
    .DATA_W(DW), .BIT_CYCLES(BITC), .TURN_CYCLES(TURNC)
  ) dut (
    .clk(clk), .reset(reset), .IO(io_line),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .busy(busy), .line_oe(line_oe), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard and event monitor
  always @(negedge clk) begin
    if (line_oe === 1'b1) oe_seen = 1'b1;
    if (frame_err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: got %h want none", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          errors++;
          $display("FAIL rx_data: got %h want %h", rx_data, exp_b);
        end
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, output int start);
    logic [DW+1:0] fr;
    fr = {stop_bit, d, 1'b0};
    @(posedge clk); #1;
    start = cyc;
    init_oe = 1'b1;
    for (int j = 0; j < DW + 2; j++) begin
      init_drv = fr[j];
      repeat (BITC) @(posedge clk);
      #1;
    end
    init_oe = 1'b0;
    init_drv = 1'b1;
  endtask

  task automatic preload(input logic [DW-1:0] d);
    @(posedge clk); #1;
    checks++;
    if (tx_ready !== !model_full) begin
      errors++;
      $display("FAIL preload_ready_before: got %b want %b", tx_ready, !model_full);
    end
    tx_valid = 1'b1;
    tx_data = d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    if (!model_full) begin
      model_full = 1'b1;
      tx_exp_q.push_back(d);
    end
    checks++;
    if (tx_ready !== 1'b0) begin
      errors++;
      $display("FAIL preload_ready_after: got %b want 0", tx_ready);
    end
  endtask

  // Follows one response frame bit by bit; optionally offers a new byte mid-frame.
  task automatic expect_tx(input int start, input bit offer, input logic [DW-1:0] odata);
    int n;
    logic [DW-1:0] d;
    logic [DW+1:0] fr;
    n = 0;
    do begin @(negedge clk); n++; end while (line_oe !== 1'b1 && n < 30);
    checks++;
    if (line_oe !== 1'b1) begin
      errors++;
      $display("FAIL tx_start_timeout: got line_oe %b want 1", line_oe);
      return;
    end
    checks++;
    if (cyc - start != TX_OFS) begin
      errors++;
      $display("FAIL tx_start_cycle: got %0d want %0d", cyc - start, TX_OFS);
    end
    model_full = 1'b0;
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_at_start: got %b want 1", tx_ready);
    end
    checks++;
    if (tx_exp_q.size() == 0) begin
      errors++;
      $display("FAIL tx_unexpected: got frame want none");
      return;
    end
    d = tx_exp_q.pop_front();
    fr = {1'b1, d, 1'b0};
    for (int j = 0; j < DW + 2; j++) begin
      for (int c = 0; c < BITC; c++) begin
        if (j != 0 || c != 0) @(negedge clk);
        checks++;
        if (line_oe !== 1'b1 || io_line !== fr[j]) begin
          errors++;
          $display("FAIL tx_bit %0d.%0d: got oe=%b io=%b want oe=1 io=%b", j, c, line_oe, io_line, fr[j]);
        end
        if (offer && j == 3 && c == 0) begin
          tx_valid = 1'b1;
          tx_data = odata;
        end
        if (offer && j == 3 && c == 1) begin
          tx_valid = 1'b0;
          model_full = 1'b1;
          tx_exp_q.push_back(odata);
          checks++;
          if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL tx_load_during_tx: got ready %b want 0", tx_ready);
          end
        end
      end
    end
    @(negedge clk);
    checks++;
    if (line_oe !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tx_end: got oe=%b busy=%b want 0 0", line_oe, busy);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (line_oe !== 1'b0 || io_line !== 1'b1) begin
      errors++;
      $display("FAIL reset_line: got oe=%b io=%b want 0 1", line_oe, io_line);
    end
    checks++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got ready=%b busy=%b want 1 0", tx_ready, busy);
    end
    checks++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_data !== '0) begin
      errors++;
      $display("FAIL reset_rx: got v=%b e=%b d=%h want 0 0 00", rx_valid, frame_err, rx_data);
    end
    checks++;
    if (state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", state_dbg, IDLE);
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_rx_only();
    int start;
    int rx0;
    rx0 = rx_cnt;
    oe_seen = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, start);
    wait_cyc(start + TX_OFS - 1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rx_only_busy_turn: got %b want 1", busy);
    end
    wait_cyc(start + TX_OFS);
    checks++;
    if (busy !== 1'b0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL rx_only_idle: got busy=%b state=%0d want 0 %0d", busy, state_dbg, IDLE);
    end
    wait_cyc(start + TX_OFS + 10);
    checks++;
    if (rx_cnt - rx0 != 1 || rx_cyc - start != STOP_OFS) begin
      errors++;
      $display("FAIL rx_only_pulse: got n=%0d at %0d want 1 at %0d", rx_cnt - rx0, rx_cyc - start, STOP_OFS);
    end
    checks++;
    if (oe_seen !== 1'b0) begin
      errors++;
      $display("FAIL rx_only_no_drive: got oe_seen=%b want 0", oe_seen);
    end
  endtask

  task automatic test_rx_with_response();
    int start;
    preload(8'h3C);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, start);
    expect_tx(start, 1'b0, '0);
    checks++;
    if (rx_data !== 8'h12) begin
      errors++;
      $display("FAIL resp_rx_data: got %h want 12", rx_data);
    end
  endtask

  task automatic test_frame_err();
    int start;
    int rx0;
    int e0;
    preload(8'h77);
    rx0 = rx_cnt;
    e0 = err_cnt;
    oe_seen = 1'b0;
    send_frame(8'h55, 1'b0, start);
    wait_cyc(start + STOP_OFS + 20);
    checks++;
    if (err_cnt - e0 != 1 || err_cyc - start != STOP_OFS) begin
      errors++;
      $display("FAIL ferr_pulse: got n=%0d at %0d want 1 at %0d", err_cnt - e0, err_cyc - start, STOP_OFS);
    end
    checks++;
    if (rx_cnt != rx0 || oe_seen !== 1'b0) begin
      errors++;
      $display("FAIL ferr_side_effects: got rx=%0d oe=%b want 0 0", rx_cnt - rx0, oe_seen);
    end
    checks++;
    if (tx_ready !== 1'b0 || rx_data !== 8'h12 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL ferr_hold: got ready=%b d=%h st=%0d want 0 12 %0d", tx_ready, rx_data, state_dbg, IDLE);
    end
  endtask

  task automatic test_glitch();
    int start;
    int rx0;
    int e0;
    rx0 = rx_cnt;
    e0 = err_cnt;
    @(posedge clk); #1;
    start = cyc;
    init_oe = 1'b1;
    init_drv = 1'b0;
    @(posedge clk); #1;
    init_oe = 1'b0;
    init_drv = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      wait_cyc(start + k);
      checks++;
      if (state_dbg !== ((k == 3 || k == 4) ? RX_START : IDLE)) begin
        errors++;
        $display("FAIL glitch_state_%0d: got %0d want %0d", k, state_dbg, (k == 3 || k == 4) ? RX_START : IDLE);
      end
    end
    wait_cyc(start + 15);
    checks++;
    if (rx_cnt != rx0 || err_cnt != e0) begin
      errors++;
      $display("FAIL glitch_pulses: got rx=%0d err=%0d want 0 0", rx_cnt - rx0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid_tx();
    int start;
    exp_q.push_back(8'h21);
    send_frame(8'h21, 1'b1, start);
    wait_cyc(start + TX_OFS + 8);
    checks++;
    if (state_dbg !== TX_DATA || line_oe !== 1'b1) begin
      errors++;
      $display("FAIL rst_tx_pre: got st=%0d oe=%b want %0d 1", state_dbg, line_oe, TX_DATA);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (line_oe !== 1'b0 || io_line !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_tx_line: got oe=%b io=%b rdy=%b busy=%b want 0 1 1 0", line_oe, io_line, tx_ready, busy);
    end
    checks++;
    if (rx_valid !== 1'b0 || frame_err !== 1'b0 || rx_data !== '0 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL rst_tx_regs: got v=%b e=%b d=%h st=%0d want 0 0 00 %0d", rx_valid, frame_err, rx_data, state_dbg, IDLE);
    end
    reset = 1'b0;
    tx_exp_q.delete();
    model_full = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back();
    int start;
    preload(8'hC3);
    preload(8'h99);
    exp_q.push_back(8'h40);
    send_frame(8'h40, 1'b1, start);
    expect_tx(start, 1'b1, 8'h5A);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b1, start);
    expect_tx(start, 1'b0, '0);
    checks++;
    if (rx_data !== 8'h0F) begin
      errors++;
      $display("FAIL b2b_rx_data: got %h want 0f", rx_data);
    end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_rx_only();
    test_rx_with_response();
    test_frame_err();
    test_glitch();
    test_reset_mid_tx();
    test_back_to_back();
    repeat (10) @(posedge clk);
    checks++;
    if (exp_q.size() != 0 || tx_exp_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained: got rx=%0d tx=%0d want 0 0", exp_q.size(), tx_exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
